// File: rtl/unencoded_tcam_pkg.sv
// Shared constants, write FSM encoding and helpers for the unencoded TCAM
// and the CAM/LUT lookup state machine that drives it.
package unencoded_tcam_pkg;

    localparam int TCAM_CMP_WIDTH    = 32;
    localparam int TCAM_DEPTH        = 32;
    localparam int TCAM_WRITE_CYCLES = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

    // Ceiling log2, never below 1 so address ports keep a legal width.
    function automatic int tcam_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/unencoded_tcam_entry.sv
// One ternary CAM entry: data/mask storage and a masked comparator.
module tcam_entry
    import unencoded_tcam_pkg::*;
#(
    parameter int CMP_WIDTH = TCAM_CMP_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [CMP_WIDTH-1:0] din,
    input  logic [CMP_WIDTH-1:0] data_mask,
    input  logic [CMP_WIDTH-1:0] cmp_din,
    input  logic [CMP_WIDTH-1:0] cmp_data_mask,
    input  logic                 suppress,
    output logic                 hit
);

    logic [CMP_WIDTH-1:0] data_q, data_d;
    logic [CMP_WIDTH-1:0] mask_q, mask_d;

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        if (we) begin
            data_d = din;
            mask_d = data_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            mask_q <= '0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
        end
    end

    // A bit agrees if either side ignores it or the values are equal.
    assign hit = (&(mask_q | cmp_data_mask | ~(data_q ^ cmp_din))) & ~suppress;

endmodule

// File: rtl/unencoded_tcam.sv
// Ternary CAM with registered multi-hot match vector and a fixed-length
// write window reported on busy.
module unencoded_tcam
    import unencoded_tcam_pkg::*;
#(
    parameter int CMP_WIDTH    = TCAM_CMP_WIDTH,
    parameter int DEPTH        = TCAM_DEPTH,
    parameter int DEPTH_BITS   = tcam_log2(DEPTH),
    parameter int WRITE_CYCLES = TCAM_WRITE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CMP_WIDTH-1:0]  cmp_din,
    input  logic [CMP_WIDTH-1:0]  cmp_data_mask,
    output logic                  match,
    output logic [DEPTH-1:0]      match_addr,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] wr_addr,
    input  logic [CMP_WIDTH-1:0]  din,
    input  logic [CMP_WIDTH-1:0]  data_mask,
    output logic                  busy
);

    wr_state_e             state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DEPTH_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [CMP_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [CMP_WIDTH-1:0]  wr_mask_q, wr_mask_d;
    logic [DEPTH-1:0]      match_addr_q, match_addr_d;
    logic [DEPTH-1:0]      hits;
    logic                  commit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_mask_d = wr_mask_q;
        commit    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (we) begin
                    wr_addr_d = wr_addr;
                    wr_data_d = din;
                    wr_mask_d = data_mask;
                    cnt_d     = 8'(WRITE_CYCLES);
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cnt_q == 8'd1) begin
                    commit  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Out-of-range addresses select no entry, so the window runs but nothing changes.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic sel;
        assign sel = (wr_addr_q == DEPTH_BITS'(g));

        tcam_entry #(
            .CMP_WIDTH(CMP_WIDTH)
        ) u_entry (
            .clk          (clk),
            .reset        (reset),
            .we           (commit && sel),
            .din          (wr_data_q),
            .data_mask    (wr_mask_q),
            .cmp_din      (cmp_din),
            .cmp_data_mask(cmp_data_mask),
            .suppress     ((state_q == ST_WRITE) && sel),
            .hit          (hits[g])
        );
    end

    assign match_addr_d = hits;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_mask_q    <= '0;
            match_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_mask_q    <= wr_mask_d;
            match_addr_q <= match_addr_d;
        end
    end

    assign match_addr = match_addr_q;
    assign match      = |match_addr_q;
    assign busy       = (state_q == ST_WRITE);

endmodule

// File: tb/tb_unencoded_tcam.sv
// Directed scoreboard bench for unencoded_tcam (default build and a
// WRITE_CYCLES=1 build).
module tb_unencoded_tcam;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cmp_din, cmp_data_mask, din, data_mask;
    logic        we;
    logic [4:0]  wr_addr;
    logic        match, busy;
    logic [31:0] match_addr;

    logic        b_reset;
    logic [31:0] b_cmp_din, b_cmp_data_mask, b_din, b_data_mask;
    logic        b_we;
    logic [4:0]  b_wr_addr;
    logic        b_match, b_busy;
    logic [31:0] b_match_addr;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    unencoded_tcam dut (
        .clk(clk), .reset(reset),
        .cmp_din(cmp_din), .cmp_data_mask(cmp_data_mask),
        .match(match), .match_addr(match_addr),
        .we(we), .wr_addr(wr_addr), .din(din), .data_mask(data_mask),
        .busy(busy)
    );

    unencoded_tcam #(.WRITE_CYCLES(1)) dut1 (
        .clk(clk), .reset(b_reset),
        .cmp_din(b_cmp_din), .cmp_data_mask(b_cmp_data_mask),
        .match(b_match), .match_addr(b_match_addr),
        .we(b_we), .wr_addr(b_wr_addr), .din(b_din), .data_mask(b_data_mask),
        .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Key goes in now; expected vector is popped one edge later.
    task automatic present(input logic [31:0] key, input logic [31:0] kmask,
                           input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string t;
        cmp_din = key;
        cmp_data_mask = kmask;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(match_addr, e, t);
        chk({31'b0, match}, {31'b0, |e}, {t, "_match"});
    endtask

    task automatic present_b(input logic [31:0] key, input logic [31:0] kmask,
                             input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string t;
        b_cmp_din = key;
        b_cmp_data_mask = kmask;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(b_match_addr, e, t);
        chk({31'b0, b_match}, {31'b0, |e}, {t, "_match"});
    endtask

    task automatic write_entry(input logic [4:0] addr, input logic [31:0] d,
                               input logic [31:0] m, output int n);
        we = 1'b1;
        wr_addr = addr;
        din = d;
        data_mask = m;
        tick();
        we = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; b_reset = 1'b1;
        we = 1'b0; wr_addr = '0; din = '0; data_mask = '0;
        cmp_din = 32'h1; cmp_data_mask = '0;
        b_we = 1'b0; b_wr_addr = '0; b_din = '0; b_data_mask = '0;
        b_cmp_din = 32'h1; b_cmp_data_mask = '0;
        tick();
        tick();
        chk(match_addr, 32'h0, "rst_match_addr");
        chk({31'b0, match}, 32'h0, "rst_match");
        chk({31'b0, busy}, 32'h0, "rst_busy");

        reset = 1'b0; b_reset = 1'b0;
        present(32'h0, 32'h0, 32'hFFFF_FFFF, "rst_key0");
        present(32'h1, 32'h0, 32'h0, "rst_key1");

        we = 1'b1; wr_addr = 5'd5; din = 32'h0A00_0001; data_mask = '0;
        cmp_din = 32'h0A00_0001;
        tick();
        we = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            chk({31'b0, match_addr[5]}, 32'h0, "busy_suppress");
            n++;
            tick();
        end
        chk({31'b0, match_addr[5]}, 32'h0, "commit_suppress");
        chk(n, 32'd16, "busy_len");
        present(32'h0A00_0001, 32'h0, 32'h0000_0020, "wr5_visible");

        reset = 1'b1;
        tick();
        reset = 1'b0;
        write_entry(5'd3, 32'h0A00_0000, 32'h0000_00FF, n);
        write_entry(5'd7, 32'h0A00_0005, 32'h0, n);
        present(32'h0A00_0005, 32'h0, 32'h0000_0088, "tern_05");
        present(32'h0A00_0006, 32'h0, 32'h0000_0008, "tern_06");
        present(32'h0A00_0006, 32'h0000_000F, 32'h0000_0088, "tern_06_km");

        we = 1'b1; wr_addr = 5'd10; din = 32'h1111_1111; data_mask = '0;
        tick();
        n = 0;
        while (busy && n < 300) begin
            if (n == 3) begin
                we = 1'b1; wr_addr = 5'd9; din = 32'h2222_2222;
            end else begin
                we = 1'b0;
            end
            n++;
            tick();
        end
        we = 1'b0;
        chk(n, 32'd16, "busy_len_ignored_we");
        present(32'h2222_2222, 32'h0, 32'h0, "e9_unchanged");
        present(32'h1111_1111, 32'h0, 32'h0000_0400, "e10_written");
        write_entry(5'd9, 32'h2222_2222, 32'h0, n);
        chk(n, 32'd16, "busy_len_e9");
        present(32'h2222_2222, 32'h0, 32'h0000_0200, "e9_written");

        we = 1'b1; wr_addr = 5'd2; din = 32'hFFFF_FFFF; data_mask = '0;
        tick();
        we = 1'b0;
        repeat (8) tick();
        chk({31'b0, busy}, 32'h1, "midwr_busy");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk({31'b0, busy}, 32'h0, "abort_busy");
        present(32'hFFFF_FFFF, 32'h0, 32'h0, "abort_nocommit");
        present(32'h0, 32'h0, 32'hFFFF_FFFF, "abort_cleared");
        chk({31'b0, busy}, 32'h0, "abort_busy_stays");

        for (int i = 0; i < 4; i++) begin
            b_we = 1'b1;
            b_wr_addr = 5'(i);
            b_din = 32'h100 + 32'(i);
            b_data_mask = '0;
            tick();
            b_we = 1'b0;
            chk({31'b0, b_busy}, 32'h1, $sformatf("w1_busy_hi_%0d", i));
            tick();
            chk({31'b0, b_busy}, 32'h0, $sformatf("w1_busy_lo_%0d", i));
        end
        present_b(32'h102, 32'h0, 32'h0000_0004, "w1_e2");
        present_b(32'h100, 32'h3, 32'h0000_000F, "w1_all4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
